// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the instruction fetch front end
package fetch_pkg;
  localparam int INSTR_WIDTH = 32;
  localparam int PC_STEP = 4;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem request/response, redirect and instruction stream signals
interface fetch_unit_if import fetch_pkg::*; #(
  parameter int ADDR_WIDTH = 32
);
  logic imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic instr_valid;
  logic instr_ready;
  logic [INSTR_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
  modport slave (
    input imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush (overrides push), no read bypass
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0] count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push_i && !flush_i;
    do_pop = pop_i && cnt_q != '0;
    wr_d = flush_i ? '0 : wr_q + PW'(do_push);
    rd_d = flush_i ? '0 : rd_q + PW'(do_pop);
    cnt_d = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk) if (!rst && do_push) assert (cnt_q != CW'(DEPTH));
  assign data_o = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generator, 1-cycle synchronous imem interface and prefetch FIFO
module fetch_unit import fetch_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  fetch_unit_if.master bus
);
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;
  localparam int CW = $clog2(DEPTH + 1);
  fetch_entry_t head, entry;
  logic [CW-1:0] count, occ;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, addr_q, addr, target;
  logic inflight_q, req, push, pop, valid, unused_ok;
  always_comb begin
    target = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    valid = !rst && count != '0;
    pop = valid && bus.instr_ready;
    // a redirect flushes the FIFO this cycle, so only the in-flight slot counts
    occ = (bus.redirect_valid ? '0 : count) + CW'(inflight_q);
    req = !rst && (occ < CW'(DEPTH) || pop);
    addr = bus.redirect_valid ? target : pc_q;
    pc_d = req ? addr + ADDR_WIDTH'(PC_STEP) : addr;
    push = !rst && inflight_q && !bus.redirect_valid;
    entry = '{instr: bus.imem_rdata, pc: addr_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      addr_q <= '0;
    end else begin
      pc_q <= pc_d;
      inflight_q <= req;
      addr_q <= addr;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(pop),
    .flush_i(bus.redirect_valid),
    .data_i(entry),
    .data_o(head),
    .count_o(count)
  );
  assign bus.imem_req = req;
  assign bus.imem_addr = addr;
  assign bus.instr_valid = valid;
  assign bus.instr = valid ? head.instr : NOP_INSTR;
  assign bus.instr_pc = valid ? head.pc : '0;
  assign unused_ok = &{1'b0, bus.redirect_pc[1:0]};
endmodule
